// File: rtl/bl_order_gen_cfg_if.sv
// Bundle between the X-engine sync/enable source and the baseline order generator.
// Latency: none, wires only. Backpressure: none; the source paces pairs with en.
// The source side uses master, the generator uses slave.
interface bl_order_gen_cfg_if #(
    parameter int N_ANTS = 8
);
    localparam int ANT_BITS = $clog2(N_ANTS);
    localparam int BL_BITS  = $clog2(N_ANTS * (N_ANTS + 1) / 2);

    logic                sync;
    logic                en;
    logic [ANT_BITS:0]   n_ants_cfg;
    logic [ANT_BITS-1:0] ant_a;
    logic [ANT_BITS-1:0] ant_b;
    logic [BL_BITS-1:0]  bl_idx;
    logic                valid;
    logic                last;
    logic                buf_sel;

    modport master (
        output sync, en, n_ants_cfg,
        input  ant_a, ant_b, bl_idx, valid, last, buf_sel
    );

    modport slave (
        input  sync, en, n_ants_cfg,
        output ant_a, ant_b, bl_idx, valid, last, buf_sel
    );
endinterface

// File: rtl/bl_order_gen_cfg.sv
// Triangular (ant_a, ant_b) baseline order generator with run-time antenna count.
// Latency: 1 cycle from an enabled edge to the registered pair on the outputs.
// Backpressure: none; en low stalls the counters and holds the outputs with valid=0.
module bl_order_gen_cfg #(
    parameter int N_ANTS        = 8,
    parameter int INCLUDE_AUTOS = 1
) (
    input logic               clk,
    input logic               rst_n,
    bl_order_gen_cfg_if.slave bus
);
    localparam int ANT_BITS = $clog2(N_ANTS);
    localparam int BL_BITS  = $clog2(N_ANTS * (N_ANTS + 1) / 2);
    localparam int NW       = ANT_BITS + 1;

    localparam logic [NW-1:0]       N_MAX   = NW'(N_ANTS);
    localparam logic [NW-1:0]       N_MIN   = NW'(2);
    localparam logic [ANT_BITS-1:0] START_B = ANT_BITS'((INCLUDE_AUTOS != 0) ? 0 : 1);

    typedef enum logic {IDLE, RUN} state_t;
    state_t state_q, state_d;

    logic [NW-1:0]       n_q, n_clamped, nm1, last_a;
    logic [ANT_BITS-1:0] a_q, b_q, a_next, b_next, a_inc;
    logic [BL_BITS-1:0]  idx_q;
    logic                at_row_end, at_frame_end, advance;

    logic [ANT_BITS-1:0] ant_a_q, ant_b_q;
    logic [BL_BITS-1:0]  bl_idx_q;
    logic                valid_q, last_q, buf_sel_q;

    always_comb begin
        n_clamped = bus.n_ants_cfg;
        if (bus.n_ants_cfg < N_MIN) begin
            n_clamped = N_MIN;
        end else if (bus.n_ants_cfg > N_MAX) begin
            n_clamped = N_MAX;
        end
    end

    // Frame ends on the last row: (n-1,n-1) with autos, (n-2,n-1) without.
    assign nm1          = n_q - NW'(1);
    assign last_a       = (INCLUDE_AUTOS != 0) ? nm1 : (nm1 - NW'(1));
    assign at_row_end   = ({1'b0, b_q} == nm1);
    assign at_frame_end = at_row_end && ({1'b0, a_q} == last_a);
    assign a_inc        = a_q + ANT_BITS'(1);

    always_comb begin
        a_next = a_q;
        b_next = b_q + ANT_BITS'(1);
        if (at_frame_end) begin
            a_next = '0;
            b_next = START_B;
        end else if (at_row_end) begin
            a_next = a_inc;
            b_next = a_inc + START_B;
        end
    end

    always_comb begin
        state_d = state_q;
        advance = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.sync) state_d = RUN;
            end
            RUN: begin
                advance = bus.en && !bus.sync;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            n_q       <= N_MAX;
            a_q       <= '0;
            b_q       <= START_B;
            idx_q     <= '0;
            ant_a_q   <= '0;
            ant_b_q   <= '0;
            bl_idx_q  <= '0;
            valid_q   <= 1'b0;
            last_q    <= 1'b0;
            buf_sel_q <= 1'b0;
        end else begin
            valid_q <= advance;
            last_q  <= advance && at_frame_end;
            if (bus.sync) begin
                n_q       <= n_clamped;
                a_q       <= '0;
                b_q       <= START_B;
                idx_q     <= '0;
                buf_sel_q <= 1'b0;
            end else begin
                // last_q marks the edge right after the final pair went out.
                if (last_q) buf_sel_q <= ~buf_sel_q;
                if (advance) begin
                    ant_a_q  <= a_q;
                    ant_b_q  <= b_q;
                    bl_idx_q <= idx_q;
                    a_q      <= a_next;
                    b_q      <= b_next;
                    idx_q    <= at_frame_end ? '0 : (idx_q + BL_BITS'(1));
                end
            end
        end
    end

    assign bus.ant_a   = ant_a_q;
    assign bus.ant_b   = ant_b_q;
    assign bus.bl_idx  = bl_idx_q;
    assign bus.valid   = valid_q;
    assign bus.last    = last_q;
    assign bus.buf_sel = buf_sel_q;
endmodule

// File: doc/bl_order_gen_cfg.md
Name: bl_order_gen_cfg

Overview:
- Parametrised successor to the X-engine baseline order generator.
- Emits one (ant_a, ant_b) baseline pair per enabled cycle in a fixed triangular order.
- Active antenna count is set at run time; the autocorrelation mode is chosen at build time.
- Flags each pair valid, flags the frame end, keeps a running baseline index, and toggles a ping-pong buffer select once per complete frame.
- Sits between the X-engine sync/enable source and the accumulator buffer addressing.

Parameters:
- N_ANTS, 8: maximum antenna count; integer >= 2.
- INCLUDE_AUTOS, 1: 1 = pairs with ant_a==ant_b are emitted; 0 = cross-correlations only.
- ANT_BITS, log2(N_ANTS): derived localparam, antenna index width.
- BL_BITS, log2(N_ANTS*(N_ANTS+1)/2): derived localparam, baseline index width.

Ports:
- clk  in  1  system clock; all logic on the rising edge.
- rst_n  in  1  asynchronous active-low reset.
- sync  in  1  one-cycle frame restart pulse.
- en  in  1  advance enable; one pair per cycle while high.
- n_ants_cfg  in  ANT_BITS+1  active antenna count; sampled only on sync.
- ant_a  out  ANT_BITS  first antenna of the current pair.
- ant_b  out  ANT_BITS  second antenna of the current pair; always >= ant_a.
- bl_idx  out  BL_BITS  position of the current pair within the frame, starting at 0.
- valid  out  1  ant_a/ant_b/bl_idx/last are meaningful this cycle.
- last  out  1  the current pair is the final pair of the frame.
- buf_sel  out  1  ping-pong buffer select.

Behaviour:
- Reset (rst_n low, asynchronous):
  - Outputs: ant_a=0, ant_b=0, bl_idx=0, valid=0, last=0, buf_sel=0.
  - State goes to IDLE; latched count n = N_ANTS.
- States: IDLE and RUN.
  - IDLE: en is ignored and valid stays 0. sync moves the block to RUN.
  - RUN: free-running. Frames repeat back-to-back until reset. sync is honoured at any time.
- On sync, in either state:
  - Latch n = clamp(n_ants_cfg, 2, N_ANTS). Values 0 and 1 become 2; values above N_ANTS become N_ANTS.
  - Load the internal counters with the start pair: (0,0) when INCLUDE_AUTOS=1, (0,1) when 0.
  - Clear the bl_idx counter and force buf_sel=0.
  - The sync cycle never emits a pair: valid=0 on the following edge, even if en=1.
- Pair order:
  - Outer loop over a = 0..n-1; inner loop over b = a..n-1 (autos on) or b = a+1..n-1 (autos off).
  - Frame length F = n(n+1)/2 with autos, n(n-1)/2 without.
- Emission timing (registered, latency 1):
  - In RUN, with en=1 and sync=0 at edge k, the current internal pair, index and last flag appear on the outputs with valid=1 after edge k, and the internal counters advance.
  - With en=0, valid=0 after the edge. ant_a/ant_b/bl_idx hold their last values and counters do not move.
- Frame end:
  - last=1 together with valid=1 exactly when bl_idx = F-1, i.e. pair (n-1,n-1) with autos, (n-2,n-1) without.
  - On that same advance, counters wrap to the start pair and bl_idx to 0.
  - buf_sel toggles on the edge after the last pair is emitted, i.e. the first output cycle of the next frame sees the new buf_sel value.
- n_ants_cfg changes between syncs have no effect.
- Simultaneous sync and en: sync wins (restart, no emission).
- sync on the same cycle as a last advance: restart takes priority; buf_sel is forced to 0, not toggled.
- Reset mid-frame aborts immediately to the reset values; a fresh sync is required to run again.
- Arithmetic: all counters are unsigned. ant_b never exceeds n-1. bl_idx never reaches F.

Test Plan:
- Defaults, sync then en held high → 36 valid pairs: (0,0),(0,1)..(0,7),(1,1)..(7,7), bl_idx 0..35, last only on (7,7). The next cycle emits (0,0) with bl_idx 0 and buf_sel=1. Repeat for a second frame: buf_sel returns to 0.
- n_ants_cfg=4, INCLUDE_AUTOS=0 → 6 pairs (0,1),(0,2),(0,3),(1,2),(1,3),(2,3); last on (2,3); wrap back to (0,1).
- n_ants_cfg=4 with autos, en toggled 1,0,0,1 → valid pattern 1,0,0,1; the outputs hold (0,0) during the gaps, then show (0,1) with bl_idx 1. The 10-pair frame ends on (3,3).
- Clamping: n_ants_cfg=1 with autos → frame (0,0),(0,1),(1,1). n_ants_cfg=15 → 36-pair frame, same as N_ANTS=8.
- Mid-frame sync at bl_idx=17 with en high → valid=0 for one cycle, then (0,0) with bl_idx 0 and buf_sel=0. sync coinciding with a last advance → buf_sel stays 0.
- rst_n low mid-frame while en=1 → all outputs 0 asynchronously. After release with en=1 and no sync, valid stays 0.
